// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request and
// holds the IF/ID register that feeds the hazard unit, with branch redirect handling.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 PCWrite,
   input  logic                 IFIDWrite,
   input  logic                 imem_en,
   input  logic                 imem_wait,
   input  logic [31:0]          imem_rdata,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   output logic [31:0]          imem_addr,
   output logic                 imem_req,
   output logic [31:0]          ifid_instr,
   output logic [31:0]          ifid_pc4,
   output logic                 ifid_valid,
   output logic [CNT_WIDTH-1:0] fetch_count,
   output logic [CNT_WIDTH-1:0] stall_count
);

   typedef enum logic {RUN, REDIRECT_PENDING} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } ifid_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [31:0]          pc_q, pc_d;
   logic [31:0]          tgt_q, tgt_d;
   ifid_t                ifid_q, ifid_d;
   logic [CNT_WIDTH-1:0] fcnt_q, scnt_q;
   logic                 fetch_inc, stall_inc;
   logic [31:0]          pc_plus4;

   assign pc_plus4    = pc_q + 32'd4;
   assign imem_addr   = pc_q;
   assign imem_req    = imem_en & enable & (state_q == RUN);
   assign ifid_instr  = ifid_q.instr;
   assign ifid_pc4    = ifid_q.pc4;
   assign ifid_valid  = ifid_q.valid;
   assign fetch_count = fcnt_q;
   assign stall_count = scnt_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      tgt_d     = tgt_q;
      ifid_d    = ifid_q;
      fetch_inc = 1'b0;
      stall_inc = enable & ~PCWrite;
      if (enable) begin
         unique case (state_q)
            RUN: begin
               if (branch_taken) begin
                  // squash keeps the held pc4; only instr/valid are meaningful once invalid
                  ifid_d.instr = NOP_INSTR;
                  ifid_d.valid = 1'b0;
                  if (imem_wait) begin
                     tgt_d   = branch_target;
                     state_d = REDIRECT_PENDING;
                  end else begin
                     pc_d = branch_target;
                  end
               end else begin
                  if (PCWrite) pc_d = pc_plus4;
                  if (IFIDWrite && !imem_wait) begin
                     ifid_d    = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
                     fetch_inc = 1'b1;
                  end
               end
            end
            REDIRECT_PENDING: begin
               if (!imem_wait) begin
                  pc_d    = tgt_q;
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         tgt_q   <= 32'h0;
         ifid_q  <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
         fcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         ifid_q  <= ifid_d;
         if (fetch_inc && fcnt_q != '1) fcnt_q <= fcnt_q + CNT_ONE;
         if (stall_inc && scnt_q != '1) scnt_q <= scnt_q + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle comparison against a behavioural
// model plus literal expectations at key points of each scenario.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          CW     = 8;
   localparam int          CMAX   = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset_n, enable, PCWrite, IFIDWrite, imem_en, imem_wait, branch_taken;
   logic [31:0]   imem_rdata, branch_target, imem_addr, ifid_instr, ifid_pc4;
   logic          imem_req, ifid_valid;
   logic [CW-1:0] fetch_count, stall_count;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .PCWrite(PCWrite),
      .IFIDWrite(IFIDWrite), .imem_en(imem_en), .imem_wait(imem_wait),
      .imem_rdata(imem_rdata), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_req(imem_req), .ifid_instr(ifid_instr),
      .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .fetch_count(fetch_count),
      .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory returns a word derived from the address being fetched.
   assign imem_rdata = word_at(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: architectural view of PC, pending redirect, IF/ID and counters.
   logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
   logic        m_pending, m_valid;
   int          m_fc, m_sc;

   always @(posedge clock) begin
      if (!reset_n) begin
         m_pc <= RST_PC; m_pending <= 1'b0; m_tgt <= 32'h0;
         m_instr <= NOP; m_pc4 <= 32'h0; m_valid <= 1'b0;
         m_fc <= 0; m_sc <= 0;
      end else if (enable) begin
         if (!PCWrite && m_sc < CMAX) m_sc <= m_sc + 1;
         if (m_pending) begin
            if (!imem_wait) begin
               m_pc <= m_tgt;
               m_pending <= 1'b0;
            end
         end else if (branch_taken) begin
            m_instr <= NOP;
            m_valid <= 1'b0;
            if (imem_wait) begin
               m_tgt <= branch_target;
               m_pending <= 1'b1;
            end else begin
               m_pc <= branch_target;
            end
         end else begin
            if (PCWrite) m_pc <= m_pc + 32'd4;
            if (IFIDWrite && !imem_wait) begin
               m_instr <= word_at(m_pc);
               m_pc4   <= m_pc + 32'd4;
               m_valid <= 1'b1;
               if (m_fc < CMAX) m_fc <= m_fc + 1;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("imem_req", {31'b0, imem_req}, {31'b0, imem_en & enable & ~m_pending});
         chk("ifid_instr", ifid_instr, m_instr);
         chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
         if (m_valid) chk("ifid_pc4", ifid_pc4, m_pc4);
         chk("fetch_count", {24'b0, fetch_count}, m_fc[31:0]);
         chk("stall_count", {24'b0, stall_count}, m_sc[31:0]);
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b1; PCWrite = 1'b0; IFIDWrite = 1'b0; imem_en = 1'b1;
      imem_wait = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

      // 1: reset then straight-line fetch
      step(2);
      check_en = 1'b1;
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
      chk("rst_instr", ifid_instr, NOP);
      chk("rst_fc", {24'b0, fetch_count}, 32'h0);
      reset_n = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1;
      step();
      chk("t1_addr4", imem_addr, 32'h4);
      chk("t1_pc4_4", ifid_pc4, 32'h4);
      chk("t1_valid", {31'b0, ifid_valid}, 32'h1);
      chk("t1_instr0", ifid_instr, 32'hC0DE_0000);
      step(2);
      chk("t1_addr12", imem_addr, 32'hC);
      chk("t1_pc4_12", ifid_pc4, 32'hC);
      chk("t1_fc3", {24'b0, fetch_count}, 32'h3);
      step();

      // 2: full stall at PC=0x10
      PCWrite = 1'b0; IFIDWrite = 1'b0;
      step(2);
      chk("t2_addr", imem_addr, 32'h10);
      chk("t2_instr", ifid_instr, 32'hC0DE_000C);
      chk("t2_sc2", {24'b0, stall_count}, 32'h2);

      // 3: taken branch, memory ready
      PCWrite = 1'b1; IFIDWrite = 1'b1;
      step(4);
      chk("t3_pre_addr", imem_addr, 32'h20);
      branch_taken = 1'b1; branch_target = 32'h200;
      step();
      branch_taken = 1'b0;
      chk("t3_addr", imem_addr, 32'h200);
      chk("t3_instr", ifid_instr, NOP);
      chk("t3_valid", {31'b0, ifid_valid}, 32'h0);
      chk("t3_fc", {24'b0, fetch_count}, 32'h8);

      // 4: taken branch while memory waits
      PCWrite = 1'b0; IFIDWrite = 1'b0;
      branch_taken = 1'b1; branch_target = 32'h400; imem_wait = 1'b1;
      step();
      branch_taken = 1'b0;
      chk("t4_req", {31'b0, imem_req}, 32'h0);
      chk("t4_hold", imem_addr, 32'h200);
      PCWrite = 1'b1; IFIDWrite = 1'b1;
      step();
      PCWrite = 1'b0; IFIDWrite = 1'b0;
      step();
      chk("t4_hold2", imem_addr, 32'h200);
      chk("t4_valid", {31'b0, ifid_valid}, 32'h0);
      imem_wait = 1'b0;
      step();
      chk("t4_addr", imem_addr, 32'h400);
      chk("t4_sc", {24'b0, stall_count}, 32'h5);
      chk("t4_req_run", {31'b0, imem_req}, 32'h1);

      // disabled stage ignores everything, including a branch
      enable = 1'b0; branch_taken = 1'b1; branch_target = 32'h900;
      step(2);
      chk("dis_addr", imem_addr, 32'h400);
      chk("dis_sc", {24'b0, stall_count}, 32'h5);
      chk("dis_req", {31'b0, imem_req}, 32'h0);
      enable = 1'b1; branch_taken = 1'b0;

      // 5: PC wrap, then counter saturation
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; PCWrite = 1'b1;
      step();
      branch_taken = 1'b0; IFIDWrite = 1'b1;
      step();
      chk("t5_wrap", imem_addr, 32'h0);
      chk("t5_pc4", ifid_pc4, 32'h0);
      chk("t5_instr", ifid_instr, 32'h3F21_FFFC);
      PCWrite = 1'b0;
      step(300);
      chk("t5_fc_sat", {24'b0, fetch_count}, CMAX);
      chk("t5_sc_sat", {24'b0, stall_count}, CMAX);
      step(3);
      chk("t5_fc_hold", {24'b0, fetch_count}, CMAX);

      // 6: reset while a redirect is pending
      IFIDWrite = 1'b0;
      branch_taken = 1'b1; branch_target = 32'h800; imem_wait = 1'b1;
      step();
      branch_taken = 1'b0;
      chk("t6_pend", {31'b0, imem_req}, 32'h0);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1; imem_wait = 1'b0;
      chk("t6_addr", imem_addr, RST_PC);
      chk("t6_valid", {31'b0, ifid_valid}, 32'h0);
      chk("t6_fc", {24'b0, fetch_count}, 32'h0);
      step();
      chk("t6_discard", imem_addr, RST_PC);
      chk("t6_run", {31'b0, imem_req}, 32'h1);

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the hazard detection unit. It owns the program counter, the instruction-memory request, and the IF/ID pipeline register, whose instruction field feeds the hazard unit's Instr input. It obeys the hazard unit's PCWrite, IFIDWrite and imem_en outputs, and applies branch redirects and IF/ID squashes. It also keeps two saturating performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on reset and squash
CNT_WIDTH, 16, width of each performance counter

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
enable  input  1  global stage enable; same net that drives the hazard unit
PCWrite  input  1  from hazard unit; advance PC
IFIDWrite  input  1  from hazard unit; load IF/ID register
imem_en  input  1  from hazard unit; issue instruction fetch
imem_wait  input  1  instruction memory not ready; imem_rdata invalid
imem_rdata  input  32  instruction word for imem_addr
branch_taken  input  1  ID-stage branch resolved taken (single-cycle pulse)
branch_target  input  32  target address; valid with branch_taken
imem_addr  output  32  fetch address; equals PC register
imem_req  output  1  fetch request
ifid_instr  output  32  IF/ID instruction; drives hazard unit Instr
ifid_pc4  output  32  IF/ID PC+4 of the held instruction
ifid_valid  output  1  IF/ID holds a real, non-squashed instruction
fetch_count  output  CNT_WIDTH  instructions loaded into IF/ID, saturating
stall_count  output  CNT_WIDTH  cycles with enable=1 and PCWrite=0, saturating

Behaviour:
- Reset (reset_n=0 at clock edge):
  - PC=RESET_PC.
  - ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0.
  - Both counters 0; FSM to RUN; redirect latch cleared.
  - Reset mid-operation discards any pending redirect.
- imem_addr = PC register (combinational). imem_req = imem_en & enable & (state==RUN).
- FSM states: RUN, REDIRECT_PENDING.
- RUN:
  - branch_taken=1 and imem_wait=0: PC<=branch_target; IF/ID<=NOP_INSTR, valid=0 (squash, overrides IFIDWrite); stay RUN.
  - branch_taken=1 and imem_wait=1: latch branch_target; squash IF/ID; go to REDIRECT_PENDING; PC unchanged.
  - Otherwise: if PCWrite=1, PC<=PC+4 (32-bit wrap, 32'hFFFF_FFFC+4=0). If IFIDWrite=1 and imem_wait=0, ifid_instr<=imem_rdata, ifid_pc4<=PC+4, ifid_valid<=1. Otherwise IF/ID holds.
- REDIRECT_PENDING:
  - imem_req=0; IF/ID holds NOP, valid=0; PCWrite and IFIDWrite ignored.
  - When imem_wait=0: PC<=latched target; go to RUN. First fetch from the target is issued the following cycle.
  - A further branch_taken in this state is ignored (ID holds a NOP, so none is legal).
- enable=0: PC, IF/ID, FSM and counters all hold, including on branch_taken. imem_req=0.
- Counters:
  - fetch_count increments on each non-squash IF/ID load with imem_wait=0.
  - stall_count increments when enable=1 and PCWrite=0, in RUN or REDIRECT_PENDING.
  - Both saturate at all-ones; no wrap.
- Latency:
  - Instruction at PC appears on ifid_instr one clock after a cycle with IFIDWrite=1, imem_wait=0.
  - A taken branch with imem_wait=0 puts the target on imem_addr in the next cycle.

Test Plan:
1. Reset low 2 cycles, then PCWrite=IFIDWrite=1, imem_rdata=PC-derived word, no waits -> imem_addr 0,4,8,12; ifid_pc4 4,8,12; fetch_count=3 after 3 loads; ifid_valid=1 from cycle 1.
2. IFIDWrite=0, PCWrite=0 for 2 cycles at PC=0x10 -> PC stays 0x10, ifid_instr unchanged, stall_count +2.
3. branch_taken=1, target=0x200, imem_wait=0 at PC=0x20 -> next cycle imem_addr=0x200, ifid_instr=NOP_INSTR, ifid_valid=0, fetch_count unchanged.
4. branch_taken=1, target=0x400, imem_wait=1 for 3 cycles -> imem_req=0 and PC unchanged until wait drops; PC=0x400 the cycle after imem_wait falls; stall_count counts all stalled cycles.
5. PC=0xFFFF_FFFC, PCWrite=1 -> PC=0x0000_0000. Separately, preload both counters to all-ones via long run -> both stay all-ones.
6. reset_n=0 while in REDIRECT_PENDING -> next cycle PC=RESET_PC, state RUN, redirect discarded, ifid_valid=0.
